wb_write_arbiter: RTL and testbench

- Write-side producer for the MIPS register file: owns the MEM/WB pipeline register and the single register-file write port.
- Muxes load data or ALU result into the write data.
- Buffers results from the multi-cycle mult/div unit in a small FIFO and drains them into idle write-port cycles.
- Drives the register file's reg_write/reg_dst/rt/rd/write_data inputs and exports a same-cycle forwarding tap.

---
 rtl/wb_write_arbiter_pkg.sv | 21 ++
 rtl/wb_write_arbiter_if.sv | 58 +++++
 rtl/wb_write_arbiter_md_result_fifo.sv | 75 +++++++
 rtl/wb_write_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_write_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Purpose : shared widths, the $0 register index and the writeback request record.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package wb_write_arbiter_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One register-file write request. The register file and the forwarding unit
    // read this same record, so keep the field order stable.
    typedef struct packed {
        logic                 we;
        logic                 reg_dst;
        logic [WB_ADDR_W-1:0] rt;
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage : wb_write_arbiter_pkg

// File: rtl/wb_write_arbiter_if.sv
// Purpose : bundles the MEM-stage, mult/div and register-file/forwarding signals of the writeback arbiter.
// Latency : n/a (wires only).
// Backpressure: md_valid/md_ready handshake on the mult/div side; the MEM side uses stall.
// Ports   : slave  = arbiter view (mem_*, stall, md_* in; md_ready, rf_*, fwd_*, md_pending out)
//           master = producer/consumer view (directions reversed).
interface wb_write_arbiter_if #(
    parameter int DATA_W = wb_write_arbiter_pkg::WB_DATA_W,
    parameter int ADDR_W = wb_write_arbiter_pkg::WB_ADDR_W
);
    // MEM stage
    logic              mem_valid;
    logic              mem_reg_write;
    logic              mem_reg_dst;
    logic [ADDR_W-1:0] mem_rt;
    logic [ADDR_W-1:0] mem_rd;
    logic              mem_to_reg;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_load_data;
    logic              stall;

    // mult/div result channel
    logic              md_valid;
    logic [ADDR_W-1:0] md_dest;
    logic [DATA_W-1:0] md_result;
    logic              md_ready;
    logic              md_pending;

    // register-file write port
    logic              rf_reg_write;
    logic              rf_reg_dst;
    logic [ADDR_W-1:0] rf_rt;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_write_data;

    // forwarding tap
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;

    modport slave (
        input  mem_valid, mem_reg_write, mem_reg_dst, mem_rt, mem_rd,
               mem_to_reg, mem_alu_result, mem_load_data, stall,
               md_valid, md_dest, md_result,
        output md_ready, md_pending,
               rf_reg_write, rf_reg_dst, rf_rt, rf_rd, rf_write_data,
               fwd_valid, fwd_addr, fwd_data
    );

    modport master (
        output mem_valid, mem_reg_write, mem_reg_dst, mem_rt, mem_rd,
               mem_to_reg, mem_alu_result, mem_load_data, stall,
               md_valid, md_dest, md_result,
        input  md_ready, md_pending,
               rf_reg_write, rf_reg_dst, rf_rt, rf_rd, rf_write_data,
               fwd_valid, fwd_addr, fwd_data
    );

endinterface : wb_write_arbiter_if

// File: rtl/wb_write_arbiter_md_result_fifo.sv
// Purpose : small circular buffer holding mult/div results until a free write-port cycle.
// Latency : a push is visible at the head the cycle after its edge; no same-cycle pass-through.
// Backpressure: full_o reflects the registered count only, so a pop does not free a slot until the next cycle.
// Ports   : clk, rst (sync, active-high); push_i/push_dat_i; pop_i; head_dat_o; count_o, full_o, empty_o.
module md_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    // Guard against a caller ignoring full/empty; the arbiter never does.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; entries are only read while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule : md_result_fifo

// File: rtl/wb_write_arbiter.sv
// Purpose : MEM/WB pipeline register plus arbitration of the single register-file write port between
//           pipeline writes and buffered mult/div results; exports a same-cycle forwarding tap.
// Latency : MEM inputs at edge N drive rf_*/fwd_* during cycle N+1; mult/div results wait in the FIFO
//           for the first cycle without a pipeline write.
// Backpressure: md_ready drops when the FIFO is full (registered count) or in reset; the pipeline side
//           never stalls here, stall only injects a bubble.
// Ports   : clk, rst (sync, active-high), wb_if (wb_write_arbiter_if.slave).
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_W   = WB_DATA_W,
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int MD_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    wb_write_arbiter_if.slave   wb_if
);
    localparam int MD_W  = DATA_W + ADDR_W;
    localparam int CNT_W = $clog2(MD_DEPTH) + 1;

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    wb_req_t           wb_q, wb_d;
    logic [ADDR_W-1:0] mem_dest;

    always_comb begin
        mem_dest = wb_if.mem_reg_dst ? wb_if.mem_rd : wb_if.mem_rt;
        wb_d     = '0;
        // A stalled cycle captures an all-zero bubble; upstream holds the instruction.
        if (!wb_if.stall) begin
            // $0 writes are dropped here because the register file does not guard them.
            wb_d.we      = wb_if.mem_valid & wb_if.mem_reg_write & (mem_dest != REG_ZERO);
            wb_d.reg_dst = wb_if.mem_reg_dst;
            wb_d.rt      = wb_if.mem_rt;
            wb_d.rd      = wb_if.mem_rd;
            wb_d.data    = wb_if.mem_to_reg ? wb_if.mem_load_data : wb_if.mem_alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    // ------------------------------------------------------------------
    // Mult/div result FIFO
    // ------------------------------------------------------------------
    logic             md_ready;
    logic             md_push;
    logic             md_pop;
    logic [MD_W-1:0]  md_head;
    logic [CNT_W-1:0] md_count;
    logic             md_full;
    logic             md_empty;

    assign md_ready = ~md_full & ~rst;
    // Results aimed at $0 complete the handshake but are discarded.
    assign md_push  = wb_if.md_valid & md_ready & (wb_if.md_dest != REG_ZERO);
    // The FIFO only gets the port when the pipeline leaves it idle.
    assign md_pop   = ~wb_q.we & ~md_empty;

    md_result_fifo #(
        .DEPTH (MD_DEPTH),
        .W     (MD_W)
    ) u_md_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (md_push),
        .push_dat_i ({wb_if.md_dest, wb_if.md_result}),
        .pop_i      (md_pop),
        .head_dat_o (md_head),
        .count_o    (md_count),
        .full_o     (md_full),
        .empty_o    (md_empty)
    );

    assign wb_if.md_ready   = md_ready;
    assign wb_if.md_pending = (md_count != '0);

    // ------------------------------------------------------------------
    // Write-port arbitration and forwarding tap
    // ------------------------------------------------------------------
    logic              rf_we;
    logic              rf_dst;
    logic [ADDR_W-1:0] rf_rt;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_dat;
    logic [ADDR_W-1:0] fwd_addr;

    always_comb begin
        rf_we    = 1'b0;
        rf_dst   = 1'b0;
        rf_rt    = '0;
        rf_rd    = '0;
        rf_dat   = '0;
        fwd_addr = '0;
        if (wb_q.we) begin
            rf_we    = 1'b1;
            rf_dst   = wb_q.reg_dst;
            rf_rt    = wb_q.rt;
            rf_rd    = wb_q.rd;
            rf_dat   = wb_q.data;
            fwd_addr = wb_q.reg_dst ? wb_q.rd : wb_q.rt;
        end else if (!md_empty) begin
            // Mult/div results always target rd with rt held at zero.
            rf_we    = 1'b1;
            rf_dst   = 1'b1;
            rf_rd    = md_head[DATA_W +: ADDR_W];
            rf_dat   = md_head[DATA_W-1:0];
            fwd_addr = md_head[DATA_W +: ADDR_W];
        end
    end

    assign wb_if.rf_reg_write  = rf_we;
    assign wb_if.rf_reg_dst    = rf_dst;
    assign wb_if.rf_rt         = rf_rt;
    assign wb_if.rf_rd         = rf_rd;
    assign wb_if.rf_write_data = rf_dat;
    assign wb_if.fwd_valid     = rf_we;
    assign wb_if.fwd_addr      = fwd_addr;
    assign wb_if.fwd_data      = rf_dat;

endmodule : wb_write_arbiter

// File: tb/tb_wb_write_arbiter.sv
// Purpose : directed self-checking bench for wb_write_arbiter.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 time unit after the next.
// Backpressure: exercises md_ready deassertion with a full mult/div FIFO.
module tb_wb_write_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    wb_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus_if ();

    wb_write_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .MD_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wb_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic dst, input logic [4:0] rt, input logic [4:0] rd,
                             input logic to_reg, input logic [31:0] alu, input logic [31:0] ld);
        bus_if.mem_valid      = 1'b1;
        bus_if.mem_reg_write  = 1'b1;
        bus_if.mem_reg_dst    = dst;
        bus_if.mem_rt         = rt;
        bus_if.mem_rd         = rd;
        bus_if.mem_to_reg     = to_reg;
        bus_if.mem_alu_result = alu;
        bus_if.mem_load_data  = ld;
    endtask

    task automatic mem_idle();
        bus_if.mem_valid     = 1'b0;
        bus_if.mem_reg_write = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // ---------------- reset with md_valid held high ----------------
        rst                   = 1'b1;
        bus_if.stall          = 1'b0;
        bus_if.mem_valid      = 1'b0;
        bus_if.mem_reg_write  = 1'b0;
        bus_if.mem_reg_dst    = 1'b0;
        bus_if.mem_rt         = '0;
        bus_if.mem_rd         = '0;
        bus_if.mem_to_reg     = 1'b0;
        bus_if.mem_alu_result = '0;
        bus_if.mem_load_data  = '0;
        bus_if.md_valid       = 1'b1;
        bus_if.md_dest        = 5'd5;
        bus_if.md_result      = 32'h5555;
        tick();
        check("rst_md_ready_c1", bus_if.md_ready, 1'b0);
        tick();
        check("rst_md_ready_c2", bus_if.md_ready, 1'b0);
        check("rst_rf_we", bus_if.rf_reg_write, 1'b0);
        check("rst_rf_data", bus_if.rf_write_data, 32'h0);
        check("rst_rf_rd", bus_if.rf_rd, 5'd0);
        check("rst_fwd_valid", bus_if.fwd_valid, 1'b0);
        check("rst_md_pending", bus_if.md_pending, 1'b0);
        rst             = 1'b0;
        bus_if.md_valid = 1'b0;
        #1;
        check("post_rst_md_ready", bus_if.md_ready, 1'b1);
        tick();
        check("post_rst_pending", bus_if.md_pending, 1'b0);
        check("post_rst_rf_we", bus_if.rf_reg_write, 1'b0);

        // ---------------- ALU / load writeback ----------------
        mem_write(1'b1, 5'd3, 5'd8, 1'b0, 32'h0000_1234, 32'h5A5A_5A5A);
        tick();
        check("alu_we", bus_if.rf_reg_write, 1'b1);
        check("alu_dst", bus_if.rf_reg_dst, 1'b1);
        check("alu_rd", bus_if.rf_rd, 5'd8);
        check("alu_rt", bus_if.rf_rt, 5'd3);
        check("alu_data", bus_if.rf_write_data, 32'h0000_1234);
        check("alu_fwd_addr", bus_if.fwd_addr, 5'd8);
        check("alu_fwd_data", bus_if.fwd_data, 32'h0000_1234);
        check("alu_fwd_valid", bus_if.fwd_valid, 1'b1);
        mem_write(1'b1, 5'd3, 5'd8, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF);
        tick();
        check("load_data", bus_if.rf_write_data, 32'hDEAD_BEEF);
        check("load_fwd_data", bus_if.fwd_data, 32'hDEAD_BEEF);
        // rt destination resolves fwd_addr to rt
        mem_write(1'b0, 5'd7, 5'd9, 1'b0, 32'h0000_0777, 32'h0);
        tick();
        check("rt_dst_bit", bus_if.rf_reg_dst, 1'b0);
        check("rt_fwd_addr", bus_if.fwd_addr, 5'd7);
        check("rt_data", bus_if.rf_write_data, 32'h0000_0777);

        // ---------------- $0 suppression ----------------
        mem_write(1'b0, 5'd0, 5'd12, 1'b0, 32'h0000_9999, 32'h0);
        tick();
        check("zero_rf_we", bus_if.rf_reg_write, 1'b0);
        check("zero_fwd_valid", bus_if.fwd_valid, 1'b0);
        mem_idle();
        bus_if.md_valid  = 1'b1;
        bus_if.md_dest   = 5'd0;
        bus_if.md_result = 32'h0000_0077;
        tick();
        bus_if.md_valid = 1'b0;
        check("zero_md_pending", bus_if.md_pending, 1'b0);
        check("zero_md_rf_we", bus_if.rf_reg_write, 1'b0);
        tick();
        check("zero_md_rf_we2", bus_if.rf_reg_write, 1'b0);

        // ---------------- conflict: md deferred behind 3 pipeline writes ----------------
        mem_write(1'b1, 5'd0, 5'd20, 1'b0, 32'h0000_0101, 32'h0);
        bus_if.md_valid  = 1'b1;
        bus_if.md_dest   = 5'd9;
        bus_if.md_result = 32'h0000_AAAA;
        tick();
        bus_if.md_valid = 1'b0;
        check("cf_w1_data", bus_if.rf_write_data, 32'h0000_0101);
        check("cf_w1_pending", bus_if.md_pending, 1'b1);
        mem_write(1'b1, 5'd0, 5'd20, 1'b0, 32'h0000_0102, 32'h0);
        tick();
        check("cf_w2_data", bus_if.rf_write_data, 32'h0000_0102);
        mem_write(1'b1, 5'd0, 5'd20, 1'b0, 32'h0000_0103, 32'h0);
        tick();
        check("cf_w3_data", bus_if.rf_write_data, 32'h0000_0103);
        check("cf_w3_pending", bus_if.md_pending, 1'b1);
        mem_idle();
        tick();
        check("cf_md_we", bus_if.rf_reg_write, 1'b1);
        check("cf_md_rd", bus_if.rf_rd, 5'd9);
        check("cf_md_rt", bus_if.rf_rt, 5'd0);
        check("cf_md_dst", bus_if.rf_reg_dst, 1'b1);
        check("cf_md_data", bus_if.rf_write_data, 32'h0000_AAAA);
        check("cf_md_fwd_addr", bus_if.fwd_addr, 5'd9);
        tick();
        check("cf_pending_fall", bus_if.md_pending, 1'b0);
        check("cf_idle_we", bus_if.rf_reg_write, 1'b0);

        // ---------------- FIFO full ----------------
        mem_write(1'b1, 5'd0, 5'd21, 1'b0, 32'h0000_2100, 32'h0);
        bus_if.md_valid  = 1'b1;
        bus_if.md_dest   = 5'd10;
        bus_if.md_result = 32'h0000_0A10;
        tick();
        check("full_ready_1", bus_if.md_ready, 1'b1);
        bus_if.md_dest   = 5'd11;
        bus_if.md_result = 32'h0000_0B11;
        tick();
        check("full_ready_2", bus_if.md_ready, 1'b0);
        bus_if.md_dest   = 5'd12;
        bus_if.md_result = 32'h0000_0C12;
        tick();
        bus_if.md_valid = 1'b0;
        check("full_ready_3", bus_if.md_ready, 1'b0);
        check("full_pipe_rd", bus_if.rf_rd, 5'd21);
        bus_if.stall = 1'b1;
        tick();
        bus_if.stall = 1'b0;
        check("full_drain_rd", bus_if.rf_rd, 5'd10);
        check("full_drain_data", bus_if.rf_write_data, 32'h0000_0A10);
        check("full_ready_popcyc", bus_if.md_ready, 1'b0);
        tick();
        check("full_ready_rise", bus_if.md_ready, 1'b1);
        check("full_pipe_again", bus_if.rf_rd, 5'd21);
        mem_idle();
        tick();
        check("full_second_rd", bus_if.rf_rd, 5'd11);
        check("full_second_data", bus_if.rf_write_data, 32'h0000_0B11);
        tick();
        check("full_third_lost", bus_if.md_pending, 1'b0);
        check("full_third_we", bus_if.rf_reg_write, 1'b0);

        // ---------------- stall bubble ----------------
        mem_write(1'b1, 5'd0, 5'd13, 1'b0, 32'h0000_1313, 32'h0);
        bus_if.stall = 1'b1;
        tick();
        check("stall_bubble_we", bus_if.rf_reg_write, 1'b0);
        bus_if.stall = 1'b0;
        tick();
        check("stall_release_we", bus_if.rf_reg_write, 1'b1);
        check("stall_release_rd", bus_if.rf_rd, 5'd13);
        check("stall_release_data", bus_if.rf_write_data, 32'h0000_1313);
        mem_idle();
        tick();
        check("stall_once_we", bus_if.rf_reg_write, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wb_write_arbiter
